regfile_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the register bank (the `dff_async_reset` array) between NUM_REQ requesters.
- Typical requesters: writeback, load return, CSR unit, debug.
- Takes a req/addr/data triple from each requester and picks one winner per cycle.
- Drives the registered wr_en/wr_addr/wr_data to the bank and returns a one-cycle gnt pulse to the winner.

---
 rtl/regfile_wr_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port between NUM_REQ requesters.
// Optional ARB_X0_DROP_EN: grants to address 0 are acked but do not assert wr_en.
module regfile_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic                             wr_stall,
  output logic [NUM_REQ-1:0]               gnt,
  output logic                             wr_en,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic [DATA_WIDTH-1:0]            wr_data,
  output logic [$clog2(NUM_REQ)-1:0]       rr_ptr_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    r_gnt;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [PTR_W-1:0]      r_rr_ptr;

  logic [NUM_REQ-1:0]    w_eligible;
  logic                  w_found;
  logic [PTR_W-1:0]      w_idx;
  logic [PTR_W-1:0]      w_win;
  logic                  w_grant;
  logic [PTR_W-1:0]      w_next_ptr;
  logic [NUM_REQ-1:0]    w_onehot;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_wr_en_next;

  // Winner selection: first eligible index scanning from the pointer, wrapping.
  always_comb begin
    w_eligible = req & ~r_gnt;
    w_found    = 1'b0;
    w_idx      = '0;
    w_win      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && w_eligible[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Next-state values for the write port and pointer.
  always_comb begin
    w_grant    = w_found & ~wr_stall;
    w_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
    w_sel_addr = req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
    w_sel_data = req_data[w_win*DATA_WIDTH +: DATA_WIDTH];
    if (w_win == PTR_W'(NUM_REQ - 1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_win + PTR_W'(1);
    end
`ifdef ARB_X0_DROP_EN
    // x0 writes are architecturally discarded; ack the requester but keep the bank idle.
    w_wr_en_next = (w_sel_addr != {ADDR_WIDTH{1'b0}});
`else
    w_wr_en_next = 1'b1;
`endif
  end

  // Registered grant, bank write port and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rr_ptr  <= '0;
    end else if (w_grant) begin
      r_gnt     <= w_onehot;
      r_wr_en   <= w_wr_en_next;
      r_wr_addr <= w_sel_addr;
      r_wr_data <= w_sel_data;
      r_rr_ptr  <= w_next_ptr;
    end else begin
      r_gnt     <= '0;
      r_wr_en   <= 1'b0;
    end
  end

  assign gnt      = r_gnt;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign rr_ptr_o = r_rr_ptr;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed test-plan steps plus
// randomized protocol-respecting traffic against a cycle-level reference model.
module tb_regfile_wr_arbiter;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            wr_stall;
  logic [N-1:0]    gnt;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [1:0]      rr_ptr_o;

  regfile_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .wr_stall(wr_stall), .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rr_ptr_o(rr_ptr_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the bank port should show after each edge.
  logic [N-1:0]  m_gnt;
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_ptr;

  // Outstanding transaction per requester for the random phase.
  logic          pend [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_data [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt = '0; m_en = 1'b0; m_addr = '0; m_data = '0; m_ptr = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"},     64'(gnt),      64'(m_gnt));
    chk({tag, ".wr_en"},   64'(wr_en),    64'(m_en));
    chk({tag, ".wr_addr"}, 64'(wr_addr),  64'(m_addr));
    chk({tag, ".wr_data"}, 64'(wr_data),  64'(m_data));
    chk({tag, ".rr_ptr"},  64'(rr_ptr_o), 64'(m_ptr));
  endtask

  // One clock: predict from current inputs, advance, compare.
  task automatic cycle(input string tag);
    int w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w = -1;
    if (!wr_stall) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (w < 0 && req[i] && !m_gnt[i]) w = i;
      end
    end
    if (w >= 0) begin
      a = req_addr[w*AW +: AW];
      d = req_data[w*DW +: DW];
    end else begin
      a = '0;
      d = '0;
    end
    @(posedge clk); #1;
    if (w >= 0) begin
      m_gnt  = '0;
      m_gnt[w] = 1'b1;
`ifdef ARB_X0_DROP_EN
      m_en   = (a != 0);
`else
      m_en   = 1'b1;
`endif
      m_addr = a;
      m_data = d;
      m_ptr  = (w + 1) % N;
    end else begin
      m_gnt = '0;
      m_en  = 1'b0;
    end
    check_all(tag);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_addr = '0; req_data = '0; wr_stall = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0; end

    // Reset state, then reset in the middle of a grant.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    set_req(0, 5'd3, 32'hDEAD_BEEF);
    rst = 1'b0;
    cycle("rst_first_gnt");
    chk("rst_first_gnt.const", 64'(gnt), 64'h1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async.gnt", 64'(gnt), 64'h0);
    chk("rst_async.wr_en", 64'(wr_en), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    cycle("rst_rearb");
    chk("rst_rearb.gnt", 64'(gnt), 64'h1);
    chk("rst_rearb.addr", 64'(wr_addr), 64'd3);
    chk("rst_rearb.data", 64'(wr_data), 64'hDEAD_BEEF);
    @(negedge clk); req = '0;
    cycle("idle0");

    // Single request, held one cycle past grant: masked, no second grant.
    @(negedge clk); set_req(2, 5'd7, 32'h1234_5678);
    cycle("single");
    chk("single.gnt", 64'(gnt), 64'h4);
    chk("single.ptr", 64'(rr_ptr_o), 64'd3);
    cycle("single_mask");
    chk("single_mask.gnt", 64'(gnt), 64'h0);
    @(negedge clk); req = '0;
    cycle("idle1");

    // All four requesting from rr_ptr=0.
    rst = 1'b1; #1; model_reset();
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 10), 32'hA000_0000 + 32'(i));
    for (int c = 0; c < 5; c++) begin
      cycle("all4");
      chk("all4.seq", 64'(gnt), 64'(4'b0001 << (c % N)));
    end
    @(negedge clk); req = '0;
    cycle("idle2");

    // Stall holds off grants and freezes the pointer.
    @(negedge clk); req = '0;
    set_req(1, 5'd21, 32'h0000_1111);
    set_req(3, 5'd23, 32'h0000_3333);
    wr_stall = 1'b1;
    for (int c = 0; c < 4; c++) cycle("stall");
    chk("stall.ptr", 64'(rr_ptr_o), 64'd1);
    @(negedge clk); wr_stall = 1'b0;
    cycle("unstall1");
    chk("unstall1.gnt", 64'(gnt), 64'h2);
    cycle("unstall2");
    chk("unstall2.gnt", 64'(gnt), 64'h8);
    @(negedge clk); req = '0;
    cycle("idle3");

    // Pointer wrap from 3 to 0.
    @(negedge clk); set_req(2, 5'd2, 32'h2222_2222);
    cycle("to_ptr3");
    @(negedge clk); req = '0;
    set_req(0, 5'd1, 32'h0000_00A0);
    set_req(3, 5'd31, 32'h0000_00A3);
    cycle("wrap1");
    chk("wrap1.gnt", 64'(gnt), 64'h8);
    chk("wrap1.ptr", 64'(rr_ptr_o), 64'd0);
    cycle("wrap2");
    chk("wrap2.gnt", 64'(gnt), 64'h1);
    @(negedge clk); req = '0;
    cycle("idle4");

    // x0 write.
    @(negedge clk); set_req(1, 5'd0, 32'hFFFF_FFFF);
    cycle("x0");
    chk("x0.gnt", 64'(gnt), 64'h2);
`ifdef ARB_X0_DROP_EN
    chk("x0.wr_en", 64'(wr_en), 64'h0);
`else
    chk("x0.wr_en", 64'(wr_en), 64'h1);
`endif
    chk("x0.addr", 64'(wr_addr), 64'h0);
    @(negedge clk); req = '0;
    cycle("idle5");

    // Random protocol-respecting traffic with random stalls.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (m_gnt[i]) pend[i] = 1'b0;
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i]   = 1'b1;
          p_addr[i] = 5'($urandom % 32);
          p_data[i] = 32'($urandom);
        end
        req[i] = pend[i];
        req_addr[i*AW +: AW] = p_addr[i];
        req_data[i*DW +: DW] = p_data[i];
      end
      wr_stall = ($urandom % 5 == 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
